// File: rtl/imem_run_ctrl.sv
// Program loader and run sequencer: host streams a program into an internal
// instruction store, then the block resets the core, serves inst from pc and
// gates pc_en for a bounded number of cycles, with pause and single-step.
// Latency: store write one clock after handshake; inst is combinational from
// pc; pc_en/err registered, so they follow their triggering input by one cycle.
// Backpressure: ld_ready is low while running and when the store is full.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ld_valid/ld_ready/ld_data/ld_last   program load handshake
//   start, halt, step, cyc_limit        run control pulses and cycle budget
//   pc, inst, pc_en, cpu_reset          core-facing instruction/enable/reset
//   busy, done, err, prog_len, cyc_count status
module imem_run_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  input  logic          start,
  input  logic          halt,
  input  logic          step,
  input  logic [CW-1:0] cyc_limit,
  input  logic [31:0]   pc,
  output logic [31:0]   inst,
  output logic          pc_en,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   prog_len,
  output logic [CW-1:0] cyc_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLR,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t        state;
  logic [AW:0]   wr_ptr;
  logic [CW-1:0] limit;
  logic          clr_cnt;   // second CLR cycle marker
  logic [31:0]   store [DEPTH];

  logic          accept;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] cnt_inc;
  logic [29:0]   word_addr;
  logic          unused_pc_lsb;

  // Loading is allowed from IDLE and DONE (a DONE load starts a fresh program
  // at address 0) and in LOAD until the store fills up.
  assign ld_ready = !reset &&
                    ((state == S_IDLE) || (state == S_DONE) ||
                     ((state == S_LOAD) && (wr_ptr != FULL)));
  assign accept   = ld_valid && ld_ready;

  // The first word of a program always lands at address 0.
  assign wr_addr  = (state == S_LOAD) ? wr_ptr[AW-1:0] : '0;
  assign cnt_inc  = cyc_count + CW'(1);

  assign busy      = (state == S_CLR) || (state == S_RUN) || (state == S_PAUSE);
  assign done      = (state == S_DONE);
  assign cpu_reset = reset || (state == S_CLR);

  // Instruction serve: the full word address is compared against prog_len so
  // that out-of-range pcs read as NOP rather than aliasing into the store.
  assign word_addr     = pc[31:2];
  assign unused_pc_lsb = ^pc[1:0];
  assign inst = (busy && (word_addr < 30'(prog_len))) ? store[pc[AW+1:2]] : 32'h0;

  // Store is only written while not busy, so reads never collide with writes.
  always_ff @(posedge clk) begin
    if (accept) begin
      store[wr_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      prog_len  <= '0;
      cyc_count <= '0;
      limit     <= '0;
      clr_cnt   <= 1'b0;
      pc_en     <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            wr_ptr <= (AW+1)'(1);
            if (ld_last) begin
              prog_len <= (AW+1)'(1);
              state    <= S_IDLE;
            end else begin
              // Old program is being overwritten; invalidate it until last.
              prog_len <= '0;
              state    <= S_LOAD;
            end
          end else if (start) begin
            if ((prog_len == '0) || (cyc_limit == '0)) begin
              err <= 1'b1;
            end else begin
              limit     <= cyc_limit;
              cyc_count <= '0;
              clr_cnt   <= 1'b0;
              state     <= S_CLR;
            end
          end
        end

        S_LOAD: begin
          if (ld_valid && (wr_ptr == FULL)) begin
            // Host keeps pushing into a full store: keep what we have.
            err      <= 1'b1;
            prog_len <= FULL;
            state    <= S_IDLE;
          end else if (accept) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
            if (ld_last) begin
              prog_len <= wr_ptr + (AW+1)'(1);
              state    <= S_IDLE;
            end
          end
        end

        S_CLR: begin
          clr_cnt <= 1'b1;
          if (clr_cnt) begin
            state <= S_RUN;
            pc_en <= 1'b1;
          end
        end

        S_RUN: begin
          // pc_en is high for every RUN cycle; the final cycle beats halt.
          cyc_count <= cnt_inc;
          if (cnt_inc == limit) begin
            state <= S_DONE;
            pc_en <= 1'b0;
          end else if (halt) begin
            state <= S_PAUSE;
            pc_en <= 1'b0;
          end
        end

        S_PAUSE: begin
          // pc_en high here means this is a single-step execution cycle.
          if (pc_en) begin
            cyc_count <= cnt_inc;
          end
          if (pc_en && (cnt_inc == limit)) begin
            state <= S_DONE;
            pc_en <= 1'b0;
          end else if (start) begin
            state <= S_RUN;
            pc_en <= 1'b1;
          end else begin
            pc_en <= step;
          end
        end

        default: begin
          state <= S_IDLE;
          pc_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_run_ctrl.sv
// Self-checking bench for imem_run_ctrl: randomized programs and run budgets
// checked against a program-image model and run-length expectations.
// Inputs are driven on the falling edge; outputs are sampled there (or #1 later).
module tb_imem_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        start;
  logic        halt;
  logic        step;
  logic [15:0] cyc_limit;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        pc_en;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;
  logic [6:0]  prog_len;
  logic [15:0] cyc_count;

  int n_vec;
  int n_err;

  // Model: program image and its length as the host loaded it.
  logic [31:0] m_mem [64];
  int          m_len;

  logic [31:0] fixed_pc [8] = '{32'h0, 32'h4, 32'h8, 32'hA, 32'h10, 32'hFC,
                                32'h100, 32'h8000_0008};

  imem_run_ctrl dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .start(start), .halt(halt), .step(step), .cyc_limit(cyc_limit),
    .pc(pc), .inst(inst), .pc_en(pc_en), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .err(err), .prog_len(prog_len), .cyc_count(cyc_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    if ((a >> 2) < m_len) return m_mem[a[7:2]];
    return 32'h0;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    r = ($urandom_range(0, m_len + 3) << 2) | ($urandom & 32'h3);
    if ($urandom_range(0, 7) == 0) r = r | 32'h4000_0000;
    return r;
  endfunction

  task automatic load_prog(input int n);
    int i = 0;
    int g = 0;
    while (i < n && g < 2000) begin
      if ($urandom_range(0, 3) == 0) begin
        ld_valid = 1'b0;
      end else begin
        ld_valid = 1'b1; ld_data = m_mem[i]; ld_last = (i == n - 1);
      end
      #1;
      if (ld_valid && ld_ready) i++;
      @(negedge clk);
      g++;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    m_len = n;
    n_vec++; if (i != n) begin n_err++; $display("FAIL load_words: accepted %0d want %0d", i, n); end
    n_vec++; if (prog_len !== 7'(n)) begin n_err++; $display("FAIL load_prog_len: got %0d want %0d", prog_len, n); end
    n_vec++; if (busy !== 1'b0 || ld_ready !== 1'b1) begin n_err++; $display("FAIL load_idle: busy %b ld_ready %b want 0/1", busy, ld_ready); end
  endtask

  // Full uninterrupted run: 2 reset cycles, lim consecutive pc_en cycles, DONE.
  task automatic run_full(input int lim);
    int highs = 0;
    int cr = 0;
    int runs = 0;
    int g = 0;
    logic prev = 1'b0;
    cyc_limit = 16'(lim); start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc_limit = 16'($urandom);
    while (!done && g < 300) begin
      pc = (g < 8) ? fixed_pc[g] : rand_pc();
      #1;
      n_vec++; if (inst !== exp_inst(pc)) begin n_err++; $display("FAIL run_inst pc=%h: got %h want %h", pc, inst, exp_inst(pc)); end
      if (cpu_reset) begin
        cr++;
        n_vec++; if (highs != 0 || cyc_count !== 16'd0) begin n_err++; $display("FAIL clr_order: highs %0d cyc_count %0d want 0/0", highs, cyc_count); end
      end
      if (pc_en) begin
        n_vec++; if (cyc_count !== 16'(highs)) begin n_err++; $display("FAIL run_count: got %0d want %0d", cyc_count, highs); end
        highs++;
        if (!prev) runs++;
      end
      prev = pc_en;
      @(negedge clk);
      g++;
    end
    n_vec++; if (cr != 2) begin n_err++; $display("FAIL clr_cycles: got %0d want 2", cr); end
    n_vec++; if (highs != lim || runs != 1) begin n_err++; $display("FAIL pc_en_run: highs %0d runs %0d want %0d/1", highs, runs, lim); end
    n_vec++; if (done !== 1'b1 || busy !== 1'b0 || pc_en !== 1'b0) begin n_err++; $display("FAIL run_end: done %b busy %b pc_en %b want 1/0/0", done, busy, pc_en); end
    n_vec++; if (cyc_count !== 16'(lim)) begin n_err++; $display("FAIL run_final_count: got %0d want %0d", cyc_count, lim); end
    pc = 32'h0; #1;
    n_vec++; if (inst !== 32'h0) begin n_err++; $display("FAIL done_inst: got %h want 0", inst); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk); #1;
    n_vec++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
    n_vec++; if (pc_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL rst_flags: pc_en %b busy %b done %b err %b want 0", pc_en, busy, done, err); end
    n_vec++; if (prog_len !== 7'd0 || cyc_count !== 16'd0) begin n_err++; $display("FAIL rst_counts: prog_len %0d cyc_count %0d want 0", prog_len, cyc_count); end
    n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL rst_ld_ready: got %b want 0", ld_ready); end
    reset = 1'b0;
    @(negedge clk);
    m_len = 0;
    n_vec++; if (ld_ready !== 1'b1 || cpu_reset !== 1'b0) begin n_err++; $display("FAIL post_rst: ld_ready %b cpu_reset %b want 1/0", ld_ready, cpu_reset); end
  endtask

  task automatic test_errors();
    int n;
    cyc_limit = 16'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_vec++; if (err !== 1'b1 || busy !== 1'b0 || pc_en !== 1'b0) begin n_err++; $display("FAIL err_empty: err %b busy %b pc_en %b want 1/0/0", err, busy, pc_en); end
    @(negedge clk);
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_empty_pulse: got %b want 0", err); end
    n = $urandom_range(1, 8);
    for (int i = 0; i < n; i++) m_mem[i] = $urandom;
    load_prog(n);
    cyc_limit = 16'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_vec++; if (err !== 1'b1 || busy !== 1'b0 || prog_len !== 7'(n)) begin n_err++; $display("FAIL err_zero_limit: err %b busy %b prog_len %0d want 1/0/%0d", err, busy, prog_len, n); end
    @(negedge clk);
    n_vec++; if (err !== 1'b0 || pc_en !== 1'b0) begin n_err++; $display("FAIL err_zero_pulse: err %b pc_en %b want 0/0", err, pc_en); end
    halt = 1'b1; step = 1'b1;
    @(negedge clk); halt = 1'b0; step = 1'b0;
    @(negedge clk);
    n_vec++; if (err !== 1'b0 || busy !== 1'b0 || pc_en !== 1'b0) begin n_err++; $display("FAIL idle_halt_step: err %b busy %b pc_en %b want 0", err, busy, pc_en); end
  endtask

  task automatic test_basic();
    m_mem[0] = 32'h2001_0005; m_mem[1] = 32'h2002_0003;
    m_mem[2] = 32'h0022_1820; m_mem[3] = 32'h0000_0000;
    load_prog(4);
    run_full(10);
  endtask

  task automatic test_back_to_back();
    int n;
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 64);
      for (int i = 0; i < n; i++) m_mem[i] = $urandom;
      load_prog(n);
      run_full($urandom_range(1, 30));
      run_full($urandom_range(1, 12));
    end
  endtask

  task automatic test_pause_step(input int lim, input int h, input int ns);
    int highs = 0;
    int tail = 0;
    int g = 0;
    cyc_limit = 16'(lim); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (highs < h && g < 200) begin
      if (pc_en) highs++;
      if (highs == h) halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      g++;
    end
    n_vec++; if (pc_en !== 1'b0 || busy !== 1'b1 || cyc_count !== 16'(h)) begin n_err++; $display("FAIL halt_stop: pc_en %b busy %b cyc_count %0d want 0/1/%0d", pc_en, busy, cyc_count, h); end
    pc = rand_pc(); #1;
    n_vec++; if (inst !== exp_inst(pc)) begin n_err++; $display("FAIL pause_inst pc=%h: got %h want %h", pc, inst, exp_inst(pc)); end
    halt = 1'b1;
    @(negedge clk); halt = 1'b0;
    n_vec++; if (pc_en !== 1'b0 || err !== 1'b0 || cyc_count !== 16'(h)) begin n_err++; $display("FAIL pause_halt: pc_en %b err %b cyc_count %0d want 0/0/%0d", pc_en, err, cyc_count, h); end
    for (int k = 0; k < ns; k++) begin
      step = 1'b1;
      @(negedge clk); step = 1'b0;
      n_vec++; if (pc_en !== 1'b1 || cyc_count !== 16'(h + k)) begin n_err++; $display("FAIL step_on: pc_en %b cyc_count %0d want 1/%0d", pc_en, cyc_count, h + k); end
      @(negedge clk);
      n_vec++; if (pc_en !== 1'b0 || cyc_count !== 16'(h + k + 1)) begin n_err++; $display("FAIL step_off: pc_en %b cyc_count %0d want 0/%0d", pc_en, cyc_count, h + k + 1); end
    end
    start = 1'b1; step = 1'($urandom_range(0, 1));
    @(negedge clk); start = 1'b0; step = 1'b0;
    g = 0;
    while (pc_en && g < 200) begin
      n_vec++; if (cyc_count !== 16'(h + ns + tail)) begin n_err++; $display("FAIL resume_count: got %0d want %0d", cyc_count, h + ns + tail); end
      tail++;
      @(negedge clk);
      g++;
    end
    n_vec++; if (tail != lim - h - ns) begin n_err++; $display("FAIL resume_run: got %0d want %0d", tail, lim - h - ns); end
    n_vec++; if (done !== 1'b1 || cyc_count !== 16'(lim)) begin n_err++; $display("FAIL pause_done: done %b cyc_count %0d want 1/%0d", done, cyc_count, lim); end
  endtask

  task automatic test_overflow();
    int acc = 0;
    int errs = 0;
    int g = 0;
    while (g < 200) begin
      if (err) begin errs++; ld_valid = 1'b0; break; end
      ld_valid = 1'b1; ld_last = 1'b0; ld_data = $urandom;
      if (ld_ready) begin
        if (acc < 64) m_mem[acc] = ld_data;
        acc++;
      end
      @(negedge clk);
      g++;
    end
    ld_valid = 1'b0;
    m_len = 64;
    n_vec++; if (acc != 64 || errs != 1) begin n_err++; $display("FAIL ovf_accept: accepted %0d err %0d want 64/1", acc, errs); end
    n_vec++; if (prog_len !== 7'd64 || busy !== 1'b0 || done !== 1'b0 || ld_ready !== 1'b1) begin n_err++; $display("FAIL ovf_state: prog_len %0d busy %b done %b ld_ready %b want 64/0/0/1", prog_len, busy, done, ld_ready); end
    @(negedge clk);
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL ovf_err_pulse: got %b want 0", err); end
    run_full(8);
  endtask

  task automatic test_reset_midrun();
    int g = 0;
    cyc_limit = 16'd40; start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!(pc_en === 1'b1 && cyc_count === 16'd7) && g < 100) begin
      @(negedge clk);
      g++;
    end
    n_vec++; if (g >= 100) begin n_err++; $display("FAIL midrun_reach: cyc_count %0d pc_en %b want 7/1", cyc_count, pc_en); end
    reset = 1'b1; #1;
    n_vec++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL midrun_cpu_reset: got %b want 1", cpu_reset); end
    @(negedge clk);
    n_vec++; if (pc_en !== 1'b0 || busy !== 1'b0 || prog_len !== 7'd0 || cpu_reset !== 1'b1) begin n_err++; $display("FAIL midrun_abort: pc_en %b busy %b prog_len %0d cpu_reset %b want 0/0/0/1", pc_en, busy, prog_len, cpu_reset); end
    reset = 1'b0; m_len = 0;
    @(negedge clk);
    cyc_limit = 16'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_vec++; if (err !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL midrun_restart: err %b busy %b want 1/0", err, busy); end
    @(negedge clk);
  endtask

  task automatic test_halt_final();
    int highs = 0;
    int g = 0;
    for (int i = 0; i < 6; i++) m_mem[i] = $urandom;
    load_prog(6);
    cyc_limit = 16'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (highs < 3 && g < 50) begin
      if (pc_en) highs++;
      if (highs == 3) halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      g++;
    end
    n_vec++; if (done !== 1'b1 || busy !== 1'b0 || pc_en !== 1'b0 || cyc_count !== 16'd3) begin n_err++; $display("FAIL halt_final: done %b busy %b pc_en %b cyc_count %0d want 1/0/0/3", done, busy, pc_en, cyc_count); end
    cyc_limit = 16'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_vec++; if (err !== 1'b1 || done !== 1'b1) begin n_err++; $display("FAIL done_zero_limit: err %b done %b want 1/1", err, done); end
    @(negedge clk);
    m_mem[0] = ~m_mem[0]; m_mem[1] = $urandom;
    load_prog(2);
    run_full(6);
  endtask

  initial begin
    n_vec = 0; n_err = 0; m_len = 0;
    reset = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    start = 1'b0; halt = 1'b0; step = 1'b0; cyc_limit = '0; pc = '0;
    test_reset();
    test_errors();
    test_basic();
    test_back_to_back();
    test_pause_step(20, 5, 3);
    begin
      int lim;
      lim = $urandom_range(6, 30);
      test_pause_step(lim, $urandom_range(1, lim - 4), $urandom_range(0, 3));
    end
    test_overflow();
    test_reset_midrun();
    test_halt_final();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_run_ctrl.md
Name: imem_run_ctrl

Overview:
- Program loader and run sequencer for the five-stage CPU core.
- A host (testbench or emulator transactor) streams instruction words into an internal instruction store through a valid/ready handshake.
- The block then resets the core, serves `inst` from the core's `pc`, and gates `pcEn`. It runs a bounded number of cycles, with pause and single-step.
- It replaces the external instruction memory and pcEn driver around the core.

Parameters:
- DEPTH, 64, instruction store size in 32-bit words (power of 2).
- AW, 6, log2(DEPTH).
- CW, 16, width of cycle limit and cycle counter.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- ld_valid  in  1  host word valid.
- ld_ready  out  1  block can accept a word.
- ld_data  in  32  instruction word.
- ld_last  in  1  marks final word of program.
- start  in  1  one-cycle pulse: begin run (IDLE/DONE) or resume (PAUSE).
- halt  in  1  one-cycle pulse: pause a run.
- step  in  1  one-cycle pulse: single cycle of execution while paused.
- cyc_limit  in  CW  cycles of pcEn to grant per run; sampled on start.
- pc  in  32  core program counter.
- inst  out  32  instruction word to core.
- pc_en  out  1  core pcEn.
- cpu_reset  out  1  core reset.
- busy  out  1  high in CLR, RUN, PAUSE.
- done  out  1  high in DONE.
- err  out  1  one-cycle pulse on illegal request.
- prog_len  out  AW+1  words in loaded program.
- cyc_count  out  CW  pcEn cycles granted in current run.

Behaviour:

Reset:
- state=IDLE; wr_ptr=0, prog_len=0, cyc_count=0, limit=0.
- pc_en=0, done=0, err=0, busy=0, ld_ready=0.
- cpu_reset=1 combinationally while reset is high.
- Reset mid-run or mid-load aborts; the store contents are don't-care, and prog_len=0 invalidates them.

States:
- IDLE
  - ld_ready=1.
  - ld_valid&ld_ready writes ld_data to store[0], wr_ptr=1, then goes to LOAD; if ld_last is set on that word, stays IDLE with prog_len=1.
  - start with prog_len=0 or cyc_limit=0: err pulse, stay IDLE.
  - Otherwise start latches limit=cyc_limit, clears cyc_count, goes to CLR.
- LOAD
  - ld_ready = (wr_ptr!=DEPTH).
  - Each accepted word writes store[wr_ptr], wr_ptr++.
  - Word with ld_last: prog_len = wr_ptr+1, go to IDLE.
  - Store full without last: ld_ready stays 0 until a last word is seen. The host must not be stalled forever, so a full store with ld_valid high pulses err, sets prog_len=DEPTH and goes to IDLE.
  - start, halt and step are ignored in LOAD.
- CLR
  - cpu_reset=1, pc_en=0 for exactly 2 cycles, then RUN.
- RUN
  - pc_en=1 every cycle; cyc_count++ per pc_en cycle.
  - In the cycle where cyc_count==limit-1, pc_en is still 1; next state is DONE.
  - halt goes to PAUSE; pc_en=0 from the next cycle.
  - Simultaneous halt and final cycle: DONE wins.
- PAUSE
  - pc_en=0.
  - step gives pc_en=1 for exactly one cycle and cyc_count++; if that reaches limit, go to DONE.
  - start returns to RUN without CLR.
  - step and start together: start wins.
  - halt is ignored.
- DONE
  - done=1, pc_en=0; counts held.
  - start: new run via CLR using the loaded program. cyc_limit=0 here gives an err pulse and stays in DONE.
  - ld_valid: wr_ptr=0 and enter the same path as an IDLE write (new program load).
- halt or step outside RUN/PAUSE: ignored, no err.

Instruction serve (combinational from pc):
- Applies in CLR, RUN and PAUSE: word index = pc[AW+1:2].
- inst = store[index] if pc[31:2] < prog_len, else 32'h0 (NOP).
- pc[1:0] is ignored.
- In IDLE, LOAD and DONE, inst = 0.
- The store is never written while busy, so there is no read/write collision.

Other rules:
- cyc_count saturates at limit and never wraps.
- err is a registered one-cycle pulse.

Test Plan:
1. Load 4 words (0x20010005, 0x20020003, 0x00221820, 0x00000000, last on 4th), start with cyc_limit=10 -> prog_len=4; cpu_reset high exactly 2 cycles; pc_en high exactly 10 consecutive cycles; done=1 and cyc_count=10 afterwards; inst for pc=0x8 reads 0x00221820; pc=0x10 gives inst=0.
2. start with prog_len=0, then with cyc_limit=0 after a load -> err single pulse each time, state unchanged, pc_en stays 0.
3. Run cyc_limit=20; halt at cyc_count=5; three step pulses two cycles apart; start -> pc_en pattern: 5 high, low, three isolated highs, then 12 more high; done at cyc_count=20.
4. Stream DEPTH+1 words with no ld_last, ld_valid held high, ld_ready monitored -> exactly 64 accepted, err pulse, prog_len=64, state IDLE.
5. Assert reset during RUN at cyc_count=7 -> next cycle pc_en=0, busy=0, prog_len=0, cpu_reset high during reset; a subsequent start gives an err pulse.
6. Halt and final-cycle coincide with cyc_limit=3 and halt on the third pc_en cycle -> DONE (done=1), not PAUSE; then a new ld_valid word starts a fresh load at address 0.
